// File: rtl/mont_mul_pipe_pkg.sv
// Shared types and constants for the pipelined multi-lane Montgomery multiplier.
package mont_mul_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int LOG_R_DEF      = 32;
  localparam int NUM_LANES_DEF  = 8;
  localparam int LATENCY        = 3;

  typedef enum logic {
    MontMode  = 1'b0,
    PlainMode = 1'b1
  } mode_e;

  typedef struct packed {
    logic  valid;
    mode_e mode;
  } stage_ctrl_t;

endpackage

// File: rtl/mont_mul_pipe_if.sv
// Beat-level handshake bundle for mont_mul_pipe: operand side and result side.
interface mont_mul_pipe_if
  import mont_mul_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LOG_R      = LOG_R_DEF,
  parameter int NUM_LANES  = NUM_LANES_DEF
);
  logic                            in_valid_i;
  logic                            in_ready_o;
  logic                            mode_i;
  logic [NUM_LANES*DATA_WIDTH-1:0] a_i;
  logic [NUM_LANES*DATA_WIDTH-1:0] b_i;
  logic [DATA_WIDTH-1:0]           q_i;
  logic [LOG_R-1:0]                q_dash_i;
  logic                            out_valid_o;
  logic                            out_ready_i;
  logic [NUM_LANES*DATA_WIDTH-1:0] res_o;
  logic [31:0]                     op_cnt_o;

  modport master (
    output in_valid_i, mode_i, a_i, b_i, q_i, q_dash_i, out_ready_i,
    input  in_ready_o, out_valid_o, res_o, op_cnt_o
  );

  modport slave (
    input  in_valid_i, mode_i, a_i, b_i, q_i, q_dash_i, out_ready_i,
    output in_ready_o, out_valid_o, res_o, op_cnt_o
  );
endinterface

// File: rtl/mont_mul_pipe_lane.sv
// One lane of the Montgomery pipeline: product, reduction factor, then reduce/select.
// All datapath registers advance together on en; only the result register is reset.
module mont_mul_lane
  import mont_mul_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LOG_R      = LOG_R_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [LOG_R-1:0]      q_dash,
  input  logic [DATA_WIDTH-1:0] q,
  input  mode_e                 mode,
  output logic [DATA_WIDTH-1:0] res
);
  localparam int PW = 2 * DATA_WIDTH;
  localparam int SW = 2 * DATA_WIDTH + 1;
  localparam int TW = DATA_WIDTH + 1;

  logic [PW-1:0]         p_next;
  logic [PW-1:0]         p1_reg;
  logic [PW-1:0]         p2_reg;
  logic [LOG_R-1:0]      m_next;
  logic [LOG_R-1:0]      m2_reg;
  logic [SW-1:0]         mq;
  logic [SW-1:0]         s;
  logic [TW-1:0]         t;
  logic [TW-1:0]         t_sub;
  logic [DATA_WIDTH-1:0] res_next;
  logic [DATA_WIDTH-1:0] res_reg;

  assign p_next = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};
  // Operands are LOG_R wide, so the product wraps to m mod R on its own.
  assign m_next = p1_reg[LOG_R-1:0] * q_dash;

  assign mq    = {{(SW-LOG_R){1'b0}}, m2_reg} * {{(SW-DATA_WIDTH){1'b0}}, q};
  assign s     = {1'b0, p2_reg} + mq;
  // t keeps one extra bit so a result in [q, 2q) is still compared correctly.
  assign t     = TW'(s >> LOG_R);
  assign t_sub = t - {1'b0, q};

  always_comb begin
    res_next = p2_reg[DATA_WIDTH-1:0];
    if (mode == MontMode) begin
      res_next = (t >= {1'b0, q}) ? DATA_WIDTH'(t_sub) : DATA_WIDTH'(t);
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      p1_reg <= p_next;
      p2_reg <= p1_reg;
      m2_reg <= m_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_reg <= '0;
    end else if (en) begin
      res_reg <= res_next;
    end
  end

  assign res = res_reg;
endmodule

// File: rtl/mont_mul_pipe.sv
// Multi-lane 3-stage Montgomery / plain-product multiplier with full backpressure.
// Define MONT_MUL_PIPE_OP_CNT_EN to build the completed-beat counter on op_cnt_o.
module mont_mul_pipe
  import mont_mul_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LOG_R      = LOG_R_DEF,
  parameter int NUM_LANES  = NUM_LANES_DEF
) (
  input logic           clk_i,
  input logic           rst_ni,
  mont_mul_pipe_if.slave bus
);
  logic                  stall;
  logic                  advance;
  logic                  out_valid_reg;
  stage_ctrl_t           ctrl_reg [LATENCY-1];
  logic [DATA_WIDTH-1:0] q1_reg;
  logic [DATA_WIDTH-1:0] q2_reg;
  logic [LOG_R-1:0]      q_dash1_reg;
  logic [DATA_WIDTH-1:0] lane_res [NUM_LANES];

  // The whole pipe freezes while the head result is refused.
  assign stall          = out_valid_reg & ~bus.out_ready_i;
  assign advance        = ~stall;
  assign bus.in_ready_o  = advance;
  assign bus.out_valid_o = out_valid_reg;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < LATENCY-1; i++) begin
        ctrl_reg[i] <= '0;
      end
      out_valid_reg <= 1'b0;
    end else if (advance) begin
      ctrl_reg[0] <= '{valid: bus.in_valid_i, mode: mode_e'(bus.mode_i)};
      for (int i = 1; i < LATENCY-1; i++) begin
        ctrl_reg[i] <= ctrl_reg[i-1];
      end
      out_valid_reg <= ctrl_reg[LATENCY-2].valid;
    end
  end

  always_ff @(posedge clk_i) begin
    if (advance) begin
      q1_reg      <= bus.q_i;
      q_dash1_reg <= bus.q_dash_i;
      q2_reg      <= q1_reg;
    end
  end

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    mont_mul_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .LOG_R     (LOG_R)
    ) u_lane (
      .clk   (clk_i),
      .rst_n (rst_ni),
      .en    (advance),
      .a     (bus.a_i[gi*DATA_WIDTH +: DATA_WIDTH]),
      .b     (bus.b_i[gi*DATA_WIDTH +: DATA_WIDTH]),
      .q_dash(q_dash1_reg),
      .q     (q2_reg),
      .mode  (ctrl_reg[LATENCY-2].mode),
      .res   (lane_res[gi])
    );
  end

  always_comb begin
    bus.res_o = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      bus.res_o[k*DATA_WIDTH +: DATA_WIDTH] = lane_res[k];
    end
  end

`ifdef MONT_MUL_PIPE_OP_CNT_EN
  logic [31:0] op_cnt_reg;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      op_cnt_reg <= '0;
    end else if (out_valid_reg & bus.out_ready_i) begin
      op_cnt_reg <= op_cnt_reg + 32'd1;
    end
  end

  assign bus.op_cnt_o = op_cnt_reg;
`else
  assign bus.op_cnt_o = '0;
`endif
endmodule
